imm_ext_stage: RTL and testbench
================================

# imm_ext_stage

Parametrised, registered immediate-generation stage between decode and the ID/EX register of the MIPS pipeline. It accepts a raw instruction immediate plus the instruction PC under a valid/ready handshake. It produces the extended/shifted immediate and the PC-relative branch target. A 2-entry buffer absorbs one cycle of downstream stall without dropping data, and a flush input discards in-flight entries on branch mispredict or hazard squash.

## Interface

Parameters:
- DATA_W, 32: datapath width; legal values are 32 and 64.
- IMM_W, 16: raw immediate width; must satisfy IMM_W < DATA_W.
- LUI_POS, 16: bit position of the immediate LSB in LUI mode; requires LUI_POS+IMM_W <= DATA_W.
- SHIFT, 2: left-shift amount for the shifted modes and the branch offset.
- PC_INC, 4: constant added to pc for the branch target.

Ports (clock and reset first):
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- flush  in  1  discard all buffered entries and any input offered this cycle.
- in_valid  in  1  input entry offered.
- in_ready  out  1  stage can accept; registered.
- imm  in  IMM_W  raw immediate.
- mode  in  3  extension mode (see Operation).
- pc  in  DATA_W  PC of the instruction.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head entry.
- out_imm  out  DATA_W  processed immediate.
- out_target  out  DATA_W  branch target.
- out_err  out  1  head entry carried an illegal mode.

## Operation

- Modes:
  - 0 ZERO: zero-extend imm.
  - 1 SIGN: sign-extend imm.
  - 2 LUI: imm placed at [LUI_POS+IMM_W-1:LUI_POS]; bits below are zero; bits above are sign-extended from imm MSB. For DATA_W=32 this is {imm,16'h0}.
  - 3 SIGN_SHL: sign-extend, then shift left by SHIFT.
  - 4 ZERO_SHL: zero-extend, then shift left by SHIFT.
  - 5–7: illegal; out_imm=0, out_err=1.
- out_target = pc + PC_INC + (sign_ext(imm) << SHIFT), truncated mod 2^DATA_W. It is computed for every mode, including illegal modes.
- Results are computed at acceptance and stored per entry: imm_result, target, err. Outputs are driven from the head entry register; there is no combinational path from the inputs to the outputs.
- Buffer: 2 entries, FIFO order, occupancy count 0..2.
  - push = in_valid & in_ready & !flush.
  - pop = out_valid & out_ready & !flush.
  - in_ready is a register, set to 1 when next count < 2.
- Count transitions:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged; head advances and the new entry is appended.
  - count=2: in_ready=0, so no push can occur.
- Flush: next cycle count=0, out_valid=0, in_ready=1. The input offered in the flush cycle is dropped. Flush has priority over push, pop and reset-release ordering.
- out_valid = (count != 0). When out_valid=0, out_imm, out_target and out_err are 0.
- Reset (reset=0 at an edge), synchronous:
  - count=0, out_valid=0, in_ready=1.
  - out_imm=0, out_target=0, out_err=0.
  - Entry storage is cleared. Reset mid-operation discards all entries.

## Timing

- Latency: input accepted at edge k is visible on the outputs after edge k when the buffer was empty, or behind the older entry otherwise.
- Throughput: 1 entry/cycle when out_ready is held high.
- One-cycle out_ready low with continuous input: the buffer fills to 2 and in_ready drops the cycle after. No entry is lost or duplicated.
- in_ready deasserts only after the edge that makes count=2. It reasserts the cycle after a pop or flush.
- Stable-output rule: while out_valid=1 and out_ready=0, out_imm, out_target and out_err hold constant.
- Arithmetic has no saturation. Carry out of DATA_W is discarded; bits shifted past DATA_W−1 are discarded.

## Test plan

- Reset, then mode=1, imm=16'h8000, pc=32'h0040_0000, out_ready=1:
  - out_imm=32'hFFFF_8000.
  - out_target=32'h003E_0004.
  - Valid one cycle after acceptance.
- Mode sweep with imm=16'hABCD, DATA_W=32:
  - ZERO → 32'h0000_ABCD.
  - LUI → 32'hABCD_0000.
  - SIGN_SHL → 32'hFFFE_AF34.
  - ZERO_SHL → 32'h0002_AF34.
  - mode=6 → out_imm=0, out_err=1.
- Backpressure: stream 4 entries with out_ready=0 for cycles 2–3.
  - in_ready=0 once count=2.
  - All 4 entries emerge in order with no loss and no duplication.
  - Outputs are stable while stalled.
- Flush with count=2 and in_valid=1 in the same cycle:
  - Next cycle out_valid=0 and in_ready=1.
  - The flush-cycle input never appears on the outputs.
- Reset asserted mid-stream with count=1:
  - Next cycle all outputs are 0 and in_ready=1.
  - The subsequent entry emerges correctly.
- DATA_W=64, LUI, imm=16'h8001:
  - out_imm=64'hFFFF_FFFF_8001_0000.
- pc=32'hFFFF_FFFC, imm=0:
  - out_target wraps to 32'h0000_0000.

Source files
------------

// File: rtl/imm_ext_stage.sv
// Registered immediate-generation stage: extends/shifts a raw immediate, computes the
// PC-relative branch target, and holds results in a 2-entry FIFO with flush.
module imm_ext_stage #(
  parameter int DATA_W  = 32,
  parameter int IMM_W   = 16,
  parameter int LUI_POS = 16,
  parameter int SHIFT   = 2,
  parameter int PC_INC  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  imm,
  input  logic [2:0]        mode,
  input  logic [DATA_W-1:0] pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_target,
  output logic              out_err
);

  localparam logic [2:0] MODE_ZERO     = 3'd0;
  localparam logic [2:0] MODE_SIGN     = 3'd1;
  localparam logic [2:0] MODE_LUI      = 3'd2;
  localparam logic [2:0] MODE_SIGN_SHL = 3'd3;
  localparam logic [2:0] MODE_ZERO_SHL = 3'd4;

  // Entry layout: {err, target, imm_result}
  localparam int ENT_W = 2 * DATA_W + 1;

  function automatic logic [DATA_W-1:0] sext(input logic [IMM_W-1:0] v);
    return {{(DATA_W - IMM_W){v[IMM_W-1]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] zext(input logic [IMM_W-1:0] v);
    return {{(DATA_W - IMM_W){1'b0}}, v};
  endfunction

  logic [DATA_W-1:0] new_imm_s;
  logic [DATA_W-1:0] new_tgt_s;
  logic              new_err_s;
  logic [ENT_W-1:0]  new_ent_s;
  logic              push_s;
  logic              pop_s;

  logic [ENT_W-1:0]  head_q, head_d;
  logic [ENT_W-1:0]  tail_q, tail_d;
  logic [1:0]        count_q, count_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  // Result computation for the entry offered this cycle
  always_comb begin
    new_err_s = 1'b0;
    new_tgt_s = pc + DATA_W'(PC_INC) + (sext(imm) << SHIFT);
    case (mode)
      MODE_ZERO:     new_imm_s = zext(imm);
      MODE_SIGN:     new_imm_s = sext(imm);
      MODE_LUI:      new_imm_s = sext(imm) << LUI_POS;
      MODE_SIGN_SHL: new_imm_s = sext(imm) << SHIFT;
      MODE_ZERO_SHL: new_imm_s = zext(imm) << SHIFT;
      default: begin
        new_imm_s = '0;
        new_err_s = 1'b1;
      end
    endcase
    new_ent_s = {new_err_s, new_tgt_s, new_imm_s};
  end

  assign push_s = in_valid & in_ready_q & ~flush;
  assign pop_s  = out_valid_q & out_ready & ~flush;

  // FIFO next state; head slot is always the oldest entry and is zero when empty
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_d = new_ent_s;
          end else begin
            tail_d = new_ent_s;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          tail_d  = '0;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_d = new_ent_s;
          end else begin
            head_d = tail_q;
            tail_d = new_ent_s;
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
    in_ready_d  = (count_d < 2'd2);
    out_valid_d = (count_d != 2'd0);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= 2'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_imm    = head_q[DATA_W-1:0];
  assign out_target = head_q[2*DATA_W-1:DATA_W];
  assign out_err    = head_q[ENT_W-1];

endmodule

// File: tb/tb_imm_ext_stage.sv
// Directed, table-driven bench for imm_ext_stage (32-bit instance plus a 64-bit
// instance driven in lockstep for the wide LUI case).
module tb_imm_ext_stage;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] imm;
  logic [2:0]  mode;
  logic [31:0] pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [31:0] out_target;
  logic        out_err;

  logic        in_ready64;
  logic        out_valid64;
  logic [63:0] out_imm64;
  logic [63:0] out_target64;
  logic        out_err64;
  logic [63:0] pc64;

  int tests;
  int fails;

  assign pc64 = {32'h0000_0000, pc};

  imm_ext_stage u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .imm(imm), .mode(mode), .pc(pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_target(out_target), .out_err(out_err)
  );

  imm_ext_stage #(.DATA_W(64)) u_dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64),
    .imm(imm), .mode(mode), .pc(pc64),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_target(out_target64), .out_err(out_err64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  mode;
    logic [15:0] imm;
    logic [31:0] pc;
    logic [31:0] exp_imm;
    logic [31:0] exp_tgt;
    logic        exp_err;
    logic        chk64;
    logic [63:0] exp_imm64;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offer one entry into an empty stage and check it one cycle later
  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clk);
    mode = v.mode; imm = v.imm; pc = v.pc;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check($sformatf("v%0d_valid", idx), 64'(out_valid), 64'd1);
    check($sformatf("v%0d_imm", idx), 64'(out_imm), 64'(v.exp_imm));
    check($sformatf("v%0d_target", idx), 64'(out_target), 64'(v.exp_tgt));
    check($sformatf("v%0d_err", idx), 64'(out_err), 64'(v.exp_err));
    if (v.chk64) begin
      check($sformatf("v%0d_imm64", idx), out_imm64, v.exp_imm64);
    end
    @(posedge clk);
  endtask

  int          sent;
  int          rcv;
  logic [31:0] held;

  initial begin
    tests = 0; fails = 0;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    imm = 16'h0000; mode = 3'd0; pc = 32'h0000_0000;

    vecs[0] = '{3'd1, 16'h8000, 32'h0040_0000, 32'hFFFF_8000, 32'h003E_0004, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_8000};
    vecs[1] = '{3'd0, 16'hABCD, 32'h0000_1000, 32'h0000_ABCD, 32'hFFFE_BF38, 1'b0, 1'b0, 64'h0};
    vecs[2] = '{3'd2, 16'hABCD, 32'h0000_1000, 32'hABCD_0000, 32'hFFFE_BF38, 1'b0, 1'b0, 64'h0};
    vecs[3] = '{3'd3, 16'hABCD, 32'h0000_1000, 32'hFFFE_AF34, 32'hFFFE_BF38, 1'b0, 1'b0, 64'h0};
    vecs[4] = '{3'd4, 16'hABCD, 32'h0000_1000, 32'h0002_AF34, 32'hFFFE_BF38, 1'b0, 1'b0, 64'h0};
    vecs[5] = '{3'd6, 16'hABCD, 32'h0000_1000, 32'h0000_0000, 32'hFFFE_BF38, 1'b1, 1'b0, 64'h0};
    vecs[6] = '{3'd1, 16'h0000, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 64'h0};
    vecs[7] = '{3'd5, 16'h0001, 32'h0000_0000, 32'h0000_0000, 32'h0000_0008, 1'b1, 1'b0, 64'h0};
    vecs[8] = '{3'd7, 16'h7FFF, 32'h0000_0000, 32'h0000_0000, 32'h0002_0000, 1'b1, 1'b0, 64'h0};
    vecs[9] = '{3'd2, 16'h8001, 32'h0000_0000, 32'h8001_0000, 32'hFFFE_0008, 1'b0, 1'b1, 64'hFFFF_FFFF_8001_0000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_imm", 64'(out_imm), 64'd0);
    check("rst_target", 64'(out_target), 64'd0);
    check("rst_err", 64'(out_err), 64'd0);

    for (int i = 0; i < 10; i++) begin
      run_vec(i, vecs[i]);
    end

    // Backpressure: four entries, consumer stalls in cycles 2 and 3
    sent = 0; rcv = 0; held = 32'h0;
    for (int c = 0; c < 20 && rcv < 4; c++) begin
      @(negedge clk);
      out_ready = !(c == 2 || c == 3);
      in_valid  = (sent < 4);
      mode = 3'd0; pc = 32'h0000_0000; imm = 16'(sent + 1);
      if (c == 2) held = out_imm;
      if (c == 3) begin
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_stall_stable", 64'(out_imm), 64'(held));
        check("bp_stall_valid", 64'(out_valid), 64'd1);
      end
      if (out_valid && out_ready) begin
        rcv++;
        check($sformatf("bp_order%0d", rcv), 64'(out_imm), 64'(rcv));
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_received", 64'(rcv), 64'd4);
    check("bp_drained", 64'(out_valid), 64'd0);

    // Flush with a full buffer and a new input offered in the same cycle
    out_ready = 1'b0; in_valid = 1'b1; mode = 3'd0; imm = 16'h0011;
    @(posedge clk);
    @(negedge clk);
    imm = 16'h0022;
    @(posedge clk);
    @(negedge clk);
    check("fl_full_in_ready", 64'(in_ready), 64'd0);
    flush = 1'b1; imm = 16'h0099;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    check("fl_imm", 64'(out_imm), 64'd0);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("fl_no_ghost", 64'(out_valid), 64'd0);
    end

    // Reset mid-stream with one entry held
    out_ready = 1'b0; in_valid = 1'b1; mode = 3'd1; imm = 16'h1234; pc = 32'h0000_0100;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("mr_held", 64'(out_valid), 64'd1);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("mr_valid", 64'(out_valid), 64'd0);
    check("mr_in_ready", 64'(in_ready), 64'd1);
    check("mr_imm", 64'(out_imm), 64'd0);
    check("mr_target", 64'(out_target), 64'd0);
    check("mr_err", 64'(out_err), 64'd0);
    run_vec(100, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
